// File: rtl/hexuart_fifo.sv
// hexuart_fifo
//   Buffered hex-dump UART transmitter for hardware debug. Records of
//   {prefix, value} are queued through a valid/ready handshake and each one
//   is sent as 8N1 characters: optional prefix char, DATABITS/4 ASCII hex
//   digits MSB first, then CR LF. Records offered while the FIFO is full are
//   dropped and counted.
//
// Ports
//   clk      in   clock, all logic on posedge
//   reset_n  in   asynchronous active-low reset
//   prefix   in   [7:0]          ASCII prefix char of the record
//   value    in   [DATABITS-1:0] word to print
//   in_valid in   record offered
//   in_ready out  FIFO not full; record accepted when in_valid & in_ready
//   tx       out  UART line, idle high
//   busy     out  record in flight or FIFO not empty
//   dropcnt  out  [15:0] records refused while full, saturating
module hexuart_fifo #(
    parameter int CLKFREQ   = 50000000,
    parameter int BAUDRATE  = 115200,
    parameter int SAMPLECLK = CLKFREQ / BAUDRATE,
    parameter int DATABITS  = 32,
    parameter int FIFOBITS  = 3,
    parameter int LOWERCASE = 0,
    parameter int PREFIX_EN = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          prefix,
    input  logic [DATABITS-1:0] value,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                tx,
    output logic                busy,
    output logic [15:0]         dropcnt
);

    localparam int DEPTH = 2 ** FIFOBITS;
    localparam int RECW  = 8 + DATABITS;
    localparam int NDIG  = DATABITS / 4;
    localparam int BW    = $clog2(SAMPLECLK);
    localparam int DW    = $clog2(NDIG) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(SAMPLECLK - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NDIG - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PREFIX = 3'd2;
    localparam logic [2:0] S_DIGIT  = 3'd3;
    localparam logic [2:0] S_CR     = 3'd4;
    localparam logic [2:0] S_LF     = 3'd5;

    logic [RECW-1:0]     mem [DEPTH];
    logic [FIFOBITS:0]   wr_ptr;
    logic [FIFOBITS:0]   rd_ptr;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [RECW-1:0]     head;
    logic [7:0]          head_pfx;
    logic [DATABITS-1:0] head_val;

    logic [2:0]          state;
    logic [9:0]          frame;
    logic [3:0]          bit_cnt;
    logic [BW-1:0]       baud_cnt;
    logic [DW-1:0]       dig_cnt;
    logic [DATABITS-1:0] shreg;
    logic [DATABITS-1:0] shifted;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (LOWERCASE != 0)
            return 8'h57 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Start bit in bit 0, stop bit in bit 9; shifted right once per bit time.
    function automatic logic [9:0] char_frame(input logic [7:0] c);
        return {1'b1, c, 1'b0};
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFOBITS] != rd_ptr[FIFOBITS]) &&
                      (wr_ptr[FIFOBITS-1:0] == rd_ptr[FIFOBITS-1:0]);
    assign push     = in_valid && !full;
    assign pop      = (state == S_LOAD);
    assign head     = mem[rd_ptr[FIFOBITS-1:0]];
    assign head_pfx = head[RECW-1 -: 8];
    assign head_val = head[DATABITS-1:0];
    assign shifted  = shreg << 4;

    assign in_ready = !full;
    assign busy     = (state != S_IDLE) || !empty;
    // tx is gated by state so an async reset forces the line high at once.
    assign tx       = (state == S_IDLE || state == S_LOAD) ? 1'b1 : frame[0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[FIFOBITS-1:0]] <= {prefix, value};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dropcnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (in_valid && full && dropcnt != 16'hffff)
                dropcnt <= dropcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            frame    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            dig_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    shreg    <= head_val;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    dig_cnt  <= '0;
                    if (PREFIX_EN != 0) begin
                        state <= S_PREFIX;
                        frame <= char_frame(head_pfx);
                    end else begin
                        state <= S_DIGIT;
                        frame <= char_frame(hex_char(head_val[DATABITS-1 -: 4]));
                    end
                end
                S_PREFIX, S_DIGIT, S_CR, S_LF: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_cnt != 4'd9) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            frame   <= {1'b1, frame[9:1]};
                        end else begin
                            // Stop bit done: load the next character in the same
                            // cycle so characters of one record run back-to-back.
                            bit_cnt <= '0;
                            case (state)
                                S_PREFIX: begin
                                    state <= S_DIGIT;
                                    frame <= char_frame(hex_char(shreg[DATABITS-1 -: 4]));
                                end
                                S_DIGIT: begin
                                    shreg <= shifted;
                                    if (dig_cnt == DIG_LAST) begin
                                        state <= S_CR;
                                        frame <= char_frame(8'h0D);
                                    end else begin
                                        dig_cnt <= dig_cnt + 1'b1;
                                        frame   <= char_frame(hex_char(shifted[DATABITS-1 -: 4]));
                                    end
                                end
                                S_CR: begin
                                    state <= S_LF;
                                    frame <= char_frame(8'h0A);
                                end
                                default: begin
                                    state <= empty ? S_IDLE : S_LOAD;
                                end
                            endcase
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hexuart_fifo.sv
module tb_hexuart_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [7:0]  prefix1;
    logic [31:0] value1;
    logic        valid1, ready1, tx1, busy1;
    logic [15:0] dropcnt1;

    logic [7:0]  prefix2;
    logic [7:0]  value2;
    logic        valid2, ready2, tx2, busy2;
    logic [15:0] dropcnt2;

    hexuart_fifo #(
        .CLKFREQ(1000000), .BAUDRATE(100000), .DATABITS(32),
        .FIFOBITS(2), .LOWERCASE(0), .PREFIX_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .prefix(prefix1), .value(value1),
        .in_valid(valid1), .in_ready(ready1), .tx(tx1), .busy(busy1),
        .dropcnt(dropcnt1)
    );

    hexuart_fifo #(
        .CLKFREQ(1000000), .BAUDRATE(100000), .DATABITS(8),
        .FIFOBITS(2), .LOWERCASE(1), .PREFIX_EN(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .prefix(prefix2), .value(value2),
        .in_valid(valid2), .in_ready(ready2), .tx(tx2), .busy(busy2),
        .dropcnt(dropcnt2)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] rx1[$];
    logic [7:0] rx2[$];
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    int ferr1 = 0;
    int ferr2 = 0;

    // UART receivers: start detected on the first low sample, bits sampled
    // mid-bit (10 clk per bit), stop bit must be high.
    bit         m1_act = 1'b0;
    int         m1_c   = 0;
    logic [7:0] m1_b   = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            m1_act <= 1'b0;
        end else if (!m1_act) begin
            if (tx1 === 1'b0) begin
                m1_act <= 1'b1;
                m1_c   <= 1;
            end
        end else begin
            m1_c <= m1_c + 1;
            if (m1_c == 5 && tx1 !== 1'b0) begin
                m1_act <= 1'b0;
            end else if (m1_c >= 15 && m1_c <= 85 && (m1_c % 10) == 5) begin
                m1_b[(m1_c - 15) / 10] <= tx1;
            end else if (m1_c == 95) begin
                rx1.push_back(m1_b);
                if (tx1 !== 1'b1) ferr1 <= ferr1 + 1;
                m1_act <= 1'b0;
            end
        end
    end

    bit         m2_act = 1'b0;
    int         m2_c   = 0;
    logic [7:0] m2_b   = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            m2_act <= 1'b0;
        end else if (!m2_act) begin
            if (tx2 === 1'b0) begin
                m2_act <= 1'b1;
                m2_c   <= 1;
            end
        end else begin
            m2_c <= m2_c + 1;
            if (m2_c == 5 && tx2 !== 1'b0) begin
                m2_act <= 1'b0;
            end else if (m2_c >= 15 && m2_c <= 85 && (m2_c % 10) == 5) begin
                m2_b[(m2_c - 15) / 10] <= tx2;
            end else if (m2_c == 95) begin
                rx2.push_back(m2_b);
                if (tx2 !== 1'b1) ferr2 <= ferr2 + 1;
                m2_act <= 1'b0;
            end
        end
    end

    // Reference model: the character stream a record should produce.
    function automatic logic [7:0] hexc(input int n, input bit lower);
        if (n < 10) return 8'(48 + n);
        return lower ? 8'(97 + n - 10) : 8'(65 + n - 10);
    endfunction

    task automatic model1(input logic [7:0] p, input logic [31:0] v);
        exp1.push_back(p);
        for (int d = 7; d >= 0; d--)
            exp1.push_back(hexc(int'((v >> (4 * d)) & 32'hF), 1'b0));
        exp1.push_back(8'h0D);
        exp1.push_back(8'h0A);
    endtask

    task automatic model2(input logic [7:0] v);
        for (int d = 1; d >= 0; d--)
            exp2.push_back(hexc(int'((v >> (4 * d)) & 8'hF), 1'b1));
        exp2.push_back(8'h0D);
        exp2.push_back(8'h0A);
    endtask

    // Offer one record for exactly one edge, then scramble the inputs.
    task automatic push1(input logic [7:0] p, input logic [31:0] v);
        @(negedge clk);
        prefix1 = p; value1 = v; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0; prefix1 = 8'($urandom); value1 = $urandom;
    endtask

    task automatic wait_idle1(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (busy1 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        valid1 = 1'b0; prefix1 = '0; value1 = '0;
        valid2 = 1'b0; prefix2 = '0; value2 = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({tx1, ready1, busy1, dropcnt1} !== {1'b1, 1'b1, 1'b0, 16'h0000})
                $display("FAIL reset_idle cyc %0d: got tx=%b rdy=%b busy=%b drop=%h, want 1 1 0 0000",
                         i, tx1, ready1, busy1, dropcnt1);
            else passed++;
            total++;
            if ({tx2, ready2, busy2, dropcnt2} !== {1'b1, 1'b1, 1'b0, 16'h0000})
                $display("FAIL reset_idle_b cyc %0d: got tx=%b rdy=%b busy=%b drop=%h, want 1 1 0 0000",
                         i, tx2, ready2, busy2, dropcnt2);
            else passed++;
        end
        total++;
        if (rx1.size() != 0 || rx2.size() != 0)
            $display("FAIL reset_no_chars: got %0d/%0d chars, want 0/0", rx1.size(), rx2.size());
        else passed++;
    endtask

    task automatic test_single;
        int elapsed, lowlen, n;
        bit ok;
        rx1.delete(); exp1.delete();
        model1(8'h41, 32'h0FFF0001);
        push1(8'h41, 32'h0FFF0001);
        elapsed = 0;
        while (tx1 !== 1'b0 && elapsed < 10) begin
            @(negedge clk);
            elapsed++;
        end
        total++;
        if (tx1 !== 1'b0 || elapsed > 3)
            $display("FAIL single_latency: got %0d clk, want <= 3", elapsed);
        else passed++;
        lowlen = 0;
        while (tx1 === 1'b0 && lowlen < 30) begin
            @(negedge clk);
            lowlen++;
            elapsed++;
        end
        total++;
        if (lowlen != 10)
            $display("FAIL single_bit_time: got %0d clk, want 10", lowlen);
        else passed++;
        wait_idle1(3000, ok, n);
        elapsed += n;
        total++;
        if (!ok || elapsed < 1095 || elapsed > 1110)
            $display("FAIL single_busy_fall: got %0d clk (idle=%0b), want 1095..1110", elapsed, ok);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (rx1.size() != exp1.size())
            $display("FAIL single_count: got %0d chars, want %0d", rx1.size(), exp1.size());
        else passed++;
        for (int i = 0; i < exp1.size(); i++) begin
            total++;
            if (i >= rx1.size() || rx1[i] !== exp1[i])
                $display("FAIL single_char[%0d]: got %h, want %h", i,
                         (i < rx1.size()) ? rx1[i] : 8'hxx, exp1[i]);
            else passed++;
        end
    endtask

    task automatic test_overflow;
        logic [7:0]  p;
        logic [31:0] v;
        int n;
        bit ok;
        rx1.delete(); exp1.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            p = 8'($urandom_range(33, 126));
            v = $urandom;
            prefix1 = p; value1 = v; valid1 = 1'b1;
            total++;
            if (ready1 !== ((i < 5) ? 1'b1 : 1'b0))
                $display("FAIL overflow_ready[%0d]: got %b, want %b", i, ready1, (i < 5));
            else passed++;
            if (i < 5) model1(p, v);
            @(negedge clk);
        end
        valid1 = 1'b0; value1 = $urandom;
        total++;
        if (dropcnt1 !== 16'd1)
            $display("FAIL overflow_dropcnt: got %0d, want 1", dropcnt1);
        else passed++;
        wait_idle1(6000, ok, n);
        total++;
        if (!ok) $display("FAIL overflow_idle: busy after %0d clk, want idle", n);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (rx1.size() != exp1.size())
            $display("FAIL overflow_count: got %0d chars, want %0d", rx1.size(), exp1.size());
        else passed++;
        for (int i = 0; i < exp1.size(); i++) begin
            total++;
            if (i >= rx1.size() || rx1[i] !== exp1[i])
                $display("FAIL overflow_char[%0d]: got %h, want %h", i,
                         (i < rx1.size()) ? rx1[i] : 8'hxx, exp1[i]);
            else passed++;
        end
    endtask

    task automatic test_random;
        logic [7:0]  p;
        logic [31:0] v;
        int cnt, n;
        bit ok;
        rx1.delete(); exp1.delete();
        cnt = $urandom_range(1, 4);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            p = 8'($urandom);
            v = $urandom;
            model1(p, v);
            push1(p, v);
        end
        total++;
        if (dropcnt1 !== 16'd1)
            $display("FAIL random_dropcnt: got %0d, want 1", dropcnt1);
        else passed++;
        wait_idle1(5000, ok, n);
        total++;
        if (!ok) $display("FAIL random_idle: busy after %0d clk, want idle", n);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (rx1.size() != exp1.size())
            $display("FAIL random_count: got %0d chars, want %0d", rx1.size(), exp1.size());
        else passed++;
        for (int i = 0; i < exp1.size(); i++) begin
            total++;
            if (i >= rx1.size() || rx1[i] !== exp1[i])
                $display("FAIL random_char[%0d]: got %h, want %h", i,
                         (i < rx1.size()) ? rx1[i] : 8'hxx, exp1[i]);
            else passed++;
        end
        total++;
        if (ferr1 != 0 || ferr2 != 0)
            $display("FAIL stop_bits: got %0d/%0d framing errors, want 0/0", ferr1, ferr2);
        else passed++;
    endtask

    task automatic test_saturate;
        logic [15:0] prev;
        bit mono;
        prefix1 = 8'h53; value1 = $urandom;
        @(negedge clk);
        valid1 = 1'b1;
        prev = dropcnt1;
        mono = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (dropcnt1 < prev) mono = 1'b0;
            prev = dropcnt1;
        end
        valid1 = 1'b0;
        total++;
        if (dropcnt1 !== 16'hffff)
            $display("FAIL saturate_value: got %h, want ffff", dropcnt1);
        else passed++;
        total++;
        if (!mono) $display("FAIL saturate_nowrap: got decrease, want monotonic");
        else passed++;
        total++;
        if (dropcnt2 !== 16'h0000)
            $display("FAIL saturate_other: got %h, want 0000", dropcnt2);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        bit ok;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({tx1, ready1, busy1, dropcnt1} !== {1'b1, 1'b1, 1'b0, 16'h0000})
            $display("FAIL rmid_reset: got tx=%b rdy=%b busy=%b drop=%h, want 1 1 0 0000",
                     tx1, ready1, busy1, dropcnt1);
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        // Nibble 5 = 'A' so digit 3 drives a low data bit when reset hits.
        push1(8'h41, ($urandom & 32'hFF0FFFFF) | 32'h00A00000);
        repeat (351) @(negedge clk);
        total++;
        if (tx1 !== 1'b0)
            $display("FAIL rmid_pre: got tx=%b, want 0", tx1);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if ({tx1, busy1, ready1} !== 3'b101)
            $display("FAIL rmid_abort: got tx=%b busy=%b rdy=%b, want 1 0 1", tx1, busy1, ready1);
        else passed++;
        rx1.delete(); exp1.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model1(8'h41, 32'h00000100);
        push1(8'h41, 32'h00000100);
        wait_idle1(3000, ok, n);
        total++;
        if (!ok) $display("FAIL rmid_idle: busy after %0d clk, want idle", n);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (rx1.size() != exp1.size())
            $display("FAIL rmid_count: got %0d chars, want %0d", rx1.size(), exp1.size());
        else passed++;
        for (int i = 0; i < exp1.size(); i++) begin
            total++;
            if (i >= rx1.size() || rx1[i] !== exp1[i])
                $display("FAIL rmid_char[%0d]: got %h, want %h", i,
                         (i < rx1.size()) ? rx1[i] : 8'hxx, exp1[i]);
            else passed++;
        end
    endtask

    task automatic test_lower_noprefix;
        logic [7:0] v;
        int n;
        rx2.delete(); exp2.delete();
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? 8'hAB : 8'($urandom);
            model2(v);
            @(negedge clk);
            prefix2 = 8'($urandom); value2 = v; valid2 = 1'b1;
            @(negedge clk);
            valid2 = 1'b0; value2 = 8'($urandom);
        end
        n = 0;
        while (busy2 !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy2 !== 1'b0) $display("FAIL lower_idle: busy after %0d clk, want idle", n);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (rx2.size() != exp2.size())
            $display("FAIL lower_count: got %0d chars, want %0d", rx2.size(), exp2.size());
        else passed++;
        for (int i = 0; i < exp2.size(); i++) begin
            total++;
            if (i >= rx2.size() || rx2[i] !== exp2[i])
                $display("FAIL lower_char[%0d]: got %h, want %h", i,
                         (i < rx2.size()) ? rx2[i] : 8'hxx, exp2[i]);
            else passed++;
        end
        total++;
        if (ferr1 != 0 || ferr2 != 0)
            $display("FAIL stop_bits_end: got %0d/%0d framing errors, want 0/0", ferr1, ferr2);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_random();
        test_saturate();
        test_reset_mid();
        test_lower_noprefix();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
